regfile_watch_checker: RTL and testbench

Synthesizable, parametrised successor to the register-print bench monitor: it snoops the CPU's register-file writeback port, keeps a shadow copy of NUM_CH watched architectural registers, and compares each against an expected value. A small FSM declares PASS once every watched register holds its expected value, or FAIL on timeout. It sits beside `cpu_top` inside `cpu_top_soc`, or in a bench, and gives self-checking tests a single `done`/`pass` pair instead of per-cycle printouts.

---
 rtl/regfile_watch_checker.sv | 100 ++++++++++
 tb/tb_regfile_watch_checker.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_watch_checker.sv
// regfile_watch_checker: snoops regfile writebacks, shadows NUM_CH watched registers, reports PASS/FAIL
// Ports:
//   clk, rst         - clock (rising edge), asynchronous active-high reset
//   start            - one-cycle pulse: latch config, clear shadows, enter RUN
//   watch_addr       - per-channel watched register index, channel i at [5i+4:5i]
//   expect_data      - per-channel expected value, channel i at [XLEN*i +: XLEN]
//   wb_en/addr/data  - snooped regfile writeback port
//   rd_sel, rd_data  - combinational shadow readback (0 for unused codes)
//   match_vec        - registered per-channel shadow==expected
//   cycle_cnt        - saturating count of RUN cycles
//   done, pass, fail - registered verdict flags
module regfile_watch_checker #(
    parameter int NUM_CH  = 3,
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            start,
    input  logic [NUM_CH*5-1:0]                             watch_addr,
    input  logic [NUM_CH*XLEN-1:0]                          expect_data,
    input  logic                                            wb_en,
    input  logic [4:0]                                      wb_addr,
    input  logic [XLEN-1:0]                                 wb_data,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  rd_sel,
    output logic [XLEN-1:0]                                 rd_data,
    output logic [NUM_CH-1:0]                               match_vec,
    output logic [CNT_W-1:0]                                cycle_cnt,
    output logic                                            done,
    output logic                                            pass,
    output logic                                            fail
);
    typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state;
    logic [4:0]        addr_q [NUM_CH];
    logic [XLEN-1:0]   exp_q  [NUM_CH];
    logic [XLEN-1:0]   shadow [NUM_CH];
    logic [NUM_CH-1:0] hit;

    // x0 is never a real write, so a channel watching x0 can never be hit
    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_CH; i++)
            hit[i] = wb_en && (wb_addr != 5'd0) && (addr_q[i] == wb_addr);
    end

    assign rd_data = (int'(rd_sel) < NUM_CH) ? shadow[rd_sel] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            match_vec <= '0;
            cycle_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i] <= '0;
                exp_q[i]  <= '0;
                shadow[i] <= '0;
            end
        end else if (start) begin
            // start wins over any same-cycle writeback and re-arms from any state
            state     <= RUN;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            cycle_cnt <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                addr_q[i]    <= watch_addr[5*i +: 5];
                exp_q[i]     <= expect_data[XLEN*i +: XLEN];
                shadow[i]    <= '0;
                match_vec[i] <= (expect_data[XLEN*i +: XLEN] == '0);
            end
        end else if (state == RUN) begin
            cycle_cnt <= (cycle_cnt == CNT_MAX) ? cycle_cnt : cycle_cnt + 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (hit[i]) begin
                    shadow[i]    <= wb_data;
                    match_vec[i] <= (wb_data == exp_q[i]);
                end
            end
            // verdict uses the registered match_vec; PASS has priority over timeout
            if (&match_vec) begin
                state <= PASS;
                done  <= 1'b1;
                pass  <= 1'b1;
            end else if (cycle_cnt == CNT_LAST) begin
                state <= FAIL;
                done  <= 1'b1;
                fail  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_watch_checker.sv
// tb_regfile_watch_checker: directed bench with a shadow-register model checked every cycle
module tb_regfile_watch_checker;
    localparam int T = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [14:0] watch_addr = '0;
    logic [95:0] expect_data = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [1:0]  rd_sel = '0;

    logic [31:0] rd_a, rd_b;
    logic [2:0]  mv_a, mv_b;
    logic [4:0]  cnt_a;
    logic [2:0]  cnt_b;
    logic        done_a, pass_a, fail_a, done_b, pass_b, fail_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_watch_checker #(.NUM_CH(3), .XLEN(32), .TIMEOUT(T)) dut_a (
        .clk(clk), .rst(rst), .start(start), .watch_addr(watch_addr), .expect_data(expect_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_sel(rd_sel), .rd_data(rd_a),
        .match_vec(mv_a), .cycle_cnt(cnt_a), .done(done_a), .pass(pass_a), .fail(fail_a)
    );

    regfile_watch_checker #(.NUM_CH(3), .XLEN(32), .TIMEOUT(4)) dut_b (
        .clk(clk), .rst(rst), .start(start), .watch_addr(watch_addr), .expect_data(expect_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_sel(rd_sel), .rd_data(rd_b),
        .match_vec(mv_b), .cycle_cnt(cnt_b), .done(done_b), .pass(pass_b), .fail(fail_b)
    );

    // Model: a channel matches exactly when its shadow equals its expected value once armed;
    // verdict is 0 idle, 1 running, 2 pass, 3 fail; cnt is cycles spent running.
    int          m_to [2] = '{T, 4};
    int          m_st [2];
    int          m_cnt [2];
    bit          m_arm [2];
    int          m_adr [2][3];
    logic [31:0] m_exp [2][3];
    logic [31:0] m_sh  [2][3];

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_cnt[k] = 0; m_arm[k] = 0;
            for (int i = 0; i < 3; i++) begin
                m_adr[k][i] = 0; m_exp[k][i] = '0; m_sh[k][i] = '0;
            end
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            model_clear();
            return;
        end
        for (int k = 0; k < 2; k++) begin
            if (start) begin
                m_st[k] = 1; m_cnt[k] = 0; m_arm[k] = 1;
                for (int i = 0; i < 3; i++) begin
                    m_adr[k][i] = int'(watch_addr[5*i +: 5]);
                    m_exp[k][i] = expect_data[32*i +: 32];
                    m_sh[k][i]  = '0;
                end
            end else if (m_st[k] == 1) begin
                bit all = 1;
                for (int i = 0; i < 3; i++) all &= (m_sh[k][i] == m_exp[k][i]);
                m_cnt[k] = (m_cnt[k] < m_to[k]) ? m_cnt[k] + 1 : m_to[k];
                if (all) m_st[k] = 2;
                else if (m_cnt[k] == m_to[k]) m_st[k] = 3;
                if (wb_en && wb_addr != 0)
                    for (int i = 0; i < 3; i++)
                        if (m_adr[k][i] == int'(wb_addr)) m_sh[k][i] = wb_data;
            end
        end
    endtask

    function automatic logic [31:0] m_mv(int k);
        logic [31:0] v = '0;
        for (int i = 0; i < 3; i++) v[i] = m_arm[k] && (m_sh[k][i] == m_exp[k][i]);
        return v;
    endfunction

    function automatic logic [31:0] m_rd(int k);
        return (rd_sel < 2'd3) ? m_sh[k][rd_sel] : 32'd0;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a.match_vec", 32'(mv_a), m_mv(0));
        chk("a.cycle_cnt", 32'(cnt_a), 32'(m_cnt[0]));
        chk("a.done", 32'(done_a), 32'(m_st[0] >= 2));
        chk("a.pass", 32'(pass_a), 32'(m_st[0] == 2));
        chk("a.fail", 32'(fail_a), 32'(m_st[0] == 3));
        chk("a.rd_data", rd_a, m_rd(0));
        chk("b.match_vec", 32'(mv_b), m_mv(1));
        chk("b.cycle_cnt", 32'(cnt_b), 32'(m_cnt[1]));
        chk("b.done", 32'(done_b), 32'(m_st[1] >= 2));
        chk("b.pass", 32'(pass_b), 32'(m_st[1] == 2));
        chk("b.fail", 32'(fail_b), 32'(m_st[1] == 3));
        chk("b.rd_data", rd_b, m_rd(1));
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        start = 1'b0;
        wb_en = 1'b0;
    endtask

    task automatic cfg(input int a0, a1, a2, input logic [31:0] e0, e1, e2);
        watch_addr  = {5'(a2), 5'(a1), 5'(a0)};
        expect_data = {e2, e1, e0};
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = 5'(a); wb_data = d;
        tick();
    endtask

    task automatic go();
        start = 1'b1;
        tick();
    endtask

    initial begin
        model_clear();
        tick();
        tick();
        rst = 1'b0;
        // idle after reset, no start
        for (int n = 0; n < 20; n++) tick();
        chk("idle.done", 32'(done_a), 32'd0);
        chk("idle.match_vec", 32'(mv_a), 32'd0);
        chk("idle.cycle_cnt", 32'(cnt_a), 32'd0);
        // in-order matching writes -> PASS two edges after last write
        cfg(27, 28, 29, 32'd5, 32'd7, 32'd12);
        go();
        chk("t2.start_cnt", 32'(cnt_a), 32'd0);
        wr(27, 32'd5);
        chk("t2.mv1", 32'(mv_a), 32'b001);
        wr(28, 32'd7);
        chk("t2.mv2", 32'(mv_a), 32'b011);
        wr(29, 32'd12);
        chk("t2.mv3", 32'(mv_a), 32'b111);
        chk("t2.pass_early", 32'(pass_a), 32'd0);
        rd_sel = 2'd2;
        tick();
        chk("t2.pass", 32'(pass_a), 32'd1);
        chk("t2.rd2", rd_a, 32'd12);
        chk("t5.b_pass_at_timeout", 32'(pass_b), 32'd1);
        chk("t5.b_fail", 32'(fail_b), 32'd0);
        chk("t5.b_cnt", 32'(cnt_b), 32'd4);
        // wrong rewrite clears match, then timeout
        rd_sel = 2'd1;
        go();
        wr(28, 32'd7);
        chk("t3.mv_set", 32'(mv_a), 32'b010);
        wr(28, 32'd9);
        chk("t3.mv_clr", 32'(mv_a), 32'b000);
        chk("t3.rd1", rd_a, 32'd9);
        for (int n = 2; n < T - 1; n++) tick();
        chk("t3.fail_early", 32'(fail_a), 32'd0);
        tick();
        chk("t3.fail", 32'(fail_a), 32'd1);
        chk("t3.cnt", 32'(cnt_a), 32'(T));
        chk("t3.pass", 32'(pass_a), 32'd0);
        chk("t3.b_fail", 32'(fail_b), 32'd1);
        // shared address and x0 channel
        cfg(5, 5, 0, 32'd3, 32'd3, 32'd0);
        go();
        chk("t4.mv_start", 32'(mv_a), 32'b100);
        wr(5, 32'd3);
        chk("t4.mv_all", 32'(mv_a), 32'b111);
        rd_sel = 2'd2;
        wr(0, 32'd9);
        chk("t4.x0_shadow", rd_a, 32'd0);
        chk("t4.pass", 32'(pass_a), 32'd1);
        rd_sel = 2'd0;
        #1;
        chk("t4.rd0", rd_a, 32'd3);
        rd_sel = 2'd3;
        #1;
        chk("t4.rd_unused", rd_a, 32'd0);
        // restart during RUN discards the same-cycle writeback
        rd_sel = 2'd0;
        cfg(27, 28, 29, 32'd5, 32'd7, 32'd12);
        go();
        wr(27, 32'd5);
        chk("t5r.mv", 32'(mv_a), 32'b001);
        start = 1'b1; wb_en = 1'b1; wb_addr = 5'd28; wb_data = 32'd7;
        tick();
        chk("t5r.mv_restart", 32'(mv_a), 32'b000);
        chk("t5r.cnt_restart", 32'(cnt_a), 32'd0);
        // asynchronous reset mid-run
        wr(27, 32'd5);
        wr(28, 32'd7);
        chk("t6.mv_before", 32'(mv_a), 32'b011);
        rst = 1'b1;
        #1;
        model_clear();
        compare_all();
        chk("t6.async_mv", 32'(mv_a), 32'd0);
        chk("t6.async_rd", rd_a, 32'd0);
        tick();
        rst = 1'b0;
        wr(27, 32'd5);
        wr(28, 32'd7);
        chk("t6.ignored_mv", 32'(mv_a), 32'd0);
        chk("t6.ignored_cnt", 32'(cnt_a), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
